mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer that shares the single RAM between the instruction-fetch requester and the data-memory requester of the MIPS32 core. Sits between the IF/MEM pipeline stages and the RAM; the RAM has combinational read and writes at the rising edge when its mode is a store. Grants one access at a time round-robin, inserts programmable wait states, rejects misaligned accesses, and returns registered read data with a one-cycle ack pulse.

## Interface
- WAIT_CYCLES, 0, extra RAM cycles per access (0..15); access phase lasts WAIT_CYCLES+1 cycles
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  32  fetch address, always a word access
- if_rdata  out  32  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse
- if_err  out  1  with if_ack: address misaligned, no RAM access made
- mem_req  in  1  data request; mem_mode/addr/wdata stable until mem_ack
- mem_mode  in  4  `IO_LW/LH/LHU/LB/LBU/SW/SH/SB` code from defs.v
- mem_addr  in  32  data address
- mem_wdata  in  32  store data, low bytes used for SH/SB
- mem_rdata  out  32  load result, extended per mode, valid while mem_ack=1
- mem_ack  out  1  one-cycle completion pulse
- mem_err  out  1  with mem_ack: misaligned, no RAM access made
- ram_mode  out  4  RAM mode; `IO_NOP` when idle
- ram_addr  out  32  RAM address (RAM decodes low 23 bits)
- ram_wdata  out  32  RAM store data
- ram_rdata  in  32  RAM combinational read data
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: sample if_req/mem_req at the edge. None → stay. One → grant it. Both → grant the port not served last; after reset the data port wins the first tie.
- On grant, latch port id, mode (fetch = `IO_LW`), addr, wdata; load wait counter with WAIT_CYCLES; update last-served pointer.
- Alignment: word (LW/SW) needs addr[1:0]=0; half (LH/LHU/SH) needs addr[0]=0; bytes always aligned. Misaligned → go IDLE→RESP directly, err=1, rdata=0, RAM never driven.
- A mem_mode of `IO_NOP` or an unknown code while mem_req=1 is treated as misaligned (err=1).
- ACCESS: ram_addr/ram_wdata driven from the latches. Load modes drive ram_mode every ACCESS cycle. Store modes drive ram_mode only in the final ACCESS cycle (counter=0), else `IO_NOP`, so exactly one RAM write occurs. Counter decrements each cycle; at counter=0 capture ram_rdata into the response register and go to RESP.
- RESP: ack (and err if set) high for exactly one cycle on the granted port only; rdata held from the register; next state IDLE unconditionally.
- The requester may change req/addr at the edge ending the ack cycle; IDLE samples the new values.
- Ungranted port outputs: ack=0, err=0, rdata=0.

## Timing
- Reset values: state IDLE, if_ack=if_err=mem_ack=mem_err=0, if_rdata=mem_rdata=0, ram_mode=`IO_NOP`, ram_addr=ram_wdata=0, busy=0, last-served=fetch (so data wins first tie), counter=0.
- ram_mode forced to `IO_NOP` in every cycle rst is high: reset in the final ACCESS cycle of a store suppresses the write; reset anywhere mid-access aborts with no ack.
- Latency, req asserted in cycle 0 with arbiter idle: ACCESS cycles 1..1+WAIT_CYCLES, ack in cycle 2+WAIT_CYCLES. Misaligned: ack+err in cycle 1.
- Throughput: one access per WAIT_CYCLES+3 cycles; a competing port waits at most one full access.
- Requests arriving during ACCESS/RESP are held by the requester and served from the next IDLE.

## Structure
- `IO_*` mode codes stay in defs.v; add `ARB_IDLE/ARB_ACCESS/ARB_RESP` state encodings (2 bits) there.
- One sub-module is natural: mem_align_check (combinational: mode, addr[1:0] → misaligned flag, is_store flag), reused by later cache/MMU work.
- Response register and load extension rely on RAM-side extension; the arbiter does not re-extend.

## Test plan
- Single fetch, WAIT_CYCLES=0, RAM[0x100]=0x3C01_8000, if_addr=0x100 → ram_mode=`IO_LW` cycle 1, if_ack cycle 2 with if_rdata=0x3C01_8000, busy low cycle 3.
- Simultaneous req first after reset: mem LB at 0x203 (byte 0x80), fetch at 0x0 → mem_ack first with 0xFFFF_FF80, if_ack 3 cycles later; repeat both → fetch served first.
- Store with WAIT_CYCLES=2: SW 0xDEAD_BEEF to 0x400 → ram_mode=`IO_SW` only in 3rd ACCESS cycle, one write, mem_ack cycle 4; follow-up LW 0x400 returns 0xDEAD_BEEF.
- Misaligned: SH at 0x401, LW at 0x402, fetch at 0x6 → err+ack in cycle 1, rdata=0, ram_mode stays `IO_NOP`, RAM unchanged.
- Reset in final ACCESS cycle of SB 0x55 to 0x10 (WAIT_CYCLES=1) → no write (RAM[0x10] unchanged), no ack, all outputs at reset values next cycle.
- Back-to-back fetches 0x0,0x4,0x8 with req held and addr advanced on each ack → acks every 3 cycles, correct words.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter: memory mode codes,
// arbiter state encoding and requester identifiers.
package mem_arbiter_pkg;

  localparam logic [3:0] IO_NOP = 4'd0;
  localparam logic [3:0] IO_LW  = 4'd1;
  localparam logic [3:0] IO_LH  = 4'd2;
  localparam logic [3:0] IO_LHU = 4'd3;
  localparam logic [3:0] IO_LB  = 4'd4;
  localparam logic [3:0] IO_LBU = 4'd5;
  localparam logic [3:0] IO_SW  = 4'd6;
  localparam logic [3:0] IO_SH  = 4'd7;
  localparam logic [3:0] IO_SB  = 4'd8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_MEM = 1'b1
  } port_e;

  function automatic logic is_store_mode(input logic [3:0] mode);
    return (mode == IO_SW) || (mode == IO_SH) || (mode == IO_SB);
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational access classifier: flags misaligned or unrecognised modes and
// whether the mode writes memory.
module mem_align_check
  import mem_arbiter_pkg::*;
(
  input  logic [3:0] mode,
  input  logic [1:0] addr_lo,
  output logic       misaligned,
  output logic       is_store
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    misaligned = 1'b1;
    is_store   = is_store_mode(mode);
    case (mode)
      IO_LW, IO_SW:         misaligned = (addr_lo != 2'b00);
      IO_LH, IO_LHU, IO_SH: misaligned = addr_lo[0];
      IO_LB, IO_LBU, IO_SB: misaligned = 1'b0;
      default:              misaligned = 1'b1;  // IO_NOP or unknown code is rejected
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM between instruction fetch and data access,
// with programmable wait states, alignment rejection and registered responses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        mem_req,
  input  logic [3:0]  mem_mode,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_err,
  output logic [3:0]  ram_mode,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  arb_state_e  state;
  port_e       port_q;
  logic        last_mem;
  logic [3:0]  mode_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        store_q;
  logic [3:0]  cnt;

  logic        grant_mem;
  logic [3:0]  sel_mode;
  logic [31:0] sel_addr;
  logic        sel_mis;
  logic        sel_store;

  // Data wins a tie unless it was the port served last.
  assign grant_mem = mem_req && (!if_req || !last_mem);
  assign sel_mode  = grant_mem ? mem_mode : IO_LW;
  assign sel_addr  = grant_mem ? mem_addr : if_addr;

  mem_align_check u_align (
    .mode       (sel_mode),
    .addr_lo    (sel_addr[1:0]),
    .misaligned (sel_mis),
    .is_store   (sel_store)
  );

  // Stores only strobe the RAM in the last access cycle so exactly one write lands;
  // rst gates this combinationally so a reset in that cycle suppresses the write.
  assign ram_mode  = (!rst && state == ARB_ACCESS && (!store_q || cnt == 4'd0)) ? mode_q : IO_NOP;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = (state != ARB_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      port_q    <= PORT_IF;
      last_mem  <= 1'b0;
      mode_q    <= IO_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      store_q   <= 1'b0;
      cnt       <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (if_req || mem_req) begin
            port_q   <= grant_mem ? PORT_MEM : PORT_IF;
            last_mem <= grant_mem;
            cnt      <= 4'(WAIT_CYCLES);
            if (sel_mis) begin
              state <= ARB_RESP;
              if (grant_mem) begin
                mem_ack <= 1'b1;
                mem_err <= 1'b1;
              end else begin
                if_ack <= 1'b1;
                if_err <= 1'b1;
              end
            end else begin
              state   <= ARB_ACCESS;
              mode_q  <= sel_mode;
              addr_q  <= sel_addr;
              wdata_q <= grant_mem ? mem_wdata : '0;
              store_q <= sel_store;
            end
          end
        end
        ARB_ACCESS: begin
          if (cnt == 4'd0) begin
            state <= ARB_RESP;
            if (port_q == PORT_MEM) begin
              mem_ack   <= 1'b1;
              mem_rdata <= ram_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ARB_RESP: begin
          state     <= ARB_IDLE;
          if_ack    <= 1'b0;
          if_err    <= 1'b0;
          if_rdata  <= '0;
          mem_ack   <= 1'b0;
          mem_err   <= 1'b0;
          mem_rdata <= '0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed RAM model and an
// in-order response scoreboard checked on every ack.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_err;
  logic        mem_req;
  logic [3:0]  mem_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic [3:0]  ram_mode;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .if_err    (if_err),
    .mem_req   (mem_req),
    .mem_mode  (mem_mode),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_err   (mem_err),
    .ram_mode  (ram_mode),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte RAM: combinational, extending read; write on the rising edge.
  logic [7:0]  ram [4096];
  logic [11:0] ra;
  int          ram_writes = 0;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [31:0] bd_data;

  assign ra = ram_addr[11:0];

  always_comb begin
    ram_rdata = '0;
    case (ram_mode)
      IO_LW:  ram_rdata = {ram[ra + 12'd3], ram[ra + 12'd2], ram[ra + 12'd1], ram[ra]};
      IO_LH:  ram_rdata = {{16{ram[ra + 12'd1][7]}}, ram[ra + 12'd1], ram[ra]};
      IO_LHU: ram_rdata = {16'h0, ram[ra + 12'd1], ram[ra]};
      IO_LB:  ram_rdata = {{24{ram[ra][7]}}, ram[ra]};
      IO_LBU: ram_rdata = {24'h0, ram[ra]};
      default: ram_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr]         <= bd_data[7:0];
      ram[bd_addr + 12'd1] <= bd_data[15:8];
      ram[bd_addr + 12'd2] <= bd_data[23:16];
      ram[bd_addr + 12'd3] <= bd_data[31:24];
    end
    case (ram_mode)
      IO_SW: begin
        ram[ra]         <= ram_wdata[7:0];
        ram[ra + 12'd1] <= ram_wdata[15:8];
        ram[ra + 12'd2] <= ram_wdata[23:16];
        ram[ra + 12'd3] <= ram_wdata[31:24];
        ram_writes      <= ram_writes + 1;
      end
      IO_SH: begin
        ram[ra]         <= ram_wdata[7:0];
        ram[ra + 12'd1] <= ram_wdata[15:8];
        ram_writes      <= ram_writes + 1;
      end
      IO_SB: begin
        ram[ra]    <= ram_wdata[7:0];
        ram_writes <= ram_writes + 1;
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] peek(input logic [11:0] a);
    return {ram[a + 12'd3], ram[a + 12'd2], ram[a + 12'd1], ram[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    tick();
    bd_we   = 1'b0;
  endtask

  // Scoreboard of expected responses, in grant order.
  typedef struct packed {
    logic        is_mem;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  function automatic exp_t mk(input logic is_mem, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.is_mem = is_mem;
    e.err    = err;
    e.rdata  = rdata;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && (if_ack || mem_ack)) begin
      if (sb.size() == 0) begin
        check("unexpected ack", 32'({if_ack, mem_ack}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb mem_ack", 32'(mem_ack), 32'(mon_e.is_mem));
        check("sb if_ack", 32'(if_ack), 32'(!mon_e.is_mem));
        if (mon_e.is_mem) begin
          check("sb mem_err", 32'(mem_err), 32'(mon_e.err));
          check("sb mem_rdata", mem_rdata, mon_e.rdata);
          check("sb idle if_rdata", if_rdata, 32'd0);
          check("sb idle if_err", 32'(if_err), 32'd0);
        end else begin
          check("sb if_err", 32'(if_err), 32'(mon_e.err));
          check("sb if_rdata", if_rdata, mon_e.rdata);
          check("sb idle mem_rdata", mem_rdata, 32'd0);
          check("sb idle mem_err", 32'(mem_err), 32'd0);
        end
      end
    end
  end

  // One access from an idle arbiter; checks latency, RAM strobes and write count.
  task automatic do_access(input string tag, input logic is_mem, input logic [3:0] mode,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rdata);
    int   lat;
    int   w0;
    logic st;
    logic done;
    lat  = exp_err ? 1 : W + 2;
    st   = (mode == IO_SW) || (mode == IO_SH) || (mode == IO_SB);
    w0   = ram_writes;
    done = 1'b0;
    sb.push_back(mk(is_mem, exp_err, exp_rdata));
    if (is_mem) begin
      mem_req = 1'b1; mem_mode = mode; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int n = 1; n <= 40 && !done; n++) begin
      tick();
      if (if_ack || mem_ack) begin
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " resp ram_mode"}, 32'(ram_mode), 32'(IO_NOP));
        done    = 1'b1;
        if_req  = 1'b0;
        mem_req = 1'b0;
      end else if (!exp_err) begin
        check({tag, " ram_mode"}, 32'(ram_mode), 32'((!st || n == W + 1) ? mode : IO_NOP));
        check({tag, " ram_addr"}, ram_addr, addr);
        if (st) check({tag, " ram_wdata"}, ram_wdata, wdata);
      end
    end
    check({tag, " ack seen"}, 32'(done), 32'd1);
    if_req  = 1'b0;
    mem_req = 1'b0;
    tick();
    check({tag, " busy after"}, 32'(busy), 32'd0);
    check({tag, " writes"}, 32'(ram_writes - w0), 32'((st && !exp_err) ? 1 : 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m1, f1, m2, w0;
    int acks [3];
    int k;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_mode = IO_NOP;
    mem_addr = '0; mem_wdata = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    tick();
    tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst if_ack", 32'({if_ack, if_err}), 32'd0);
    check("rst mem_ack", 32'({mem_ack, mem_err}), 32'd0);
    check("rst if_rdata", if_rdata, 32'd0);
    check("rst mem_rdata", mem_rdata, 32'd0);
    check("rst ram_mode", 32'(ram_mode), 32'(IO_NOP));
    check("rst ram_addr", ram_addr, 32'd0);
    check("rst ram_wdata", ram_wdata, 32'd0);

    poke(12'h100, 32'h3C01_8000);
    poke(12'h200, 32'h8000_0000);
    poke(12'h000, 32'hA000_0000);
    poke(12'h004, 32'hA000_0004);
    poke(12'h008, 32'hA000_0008);
    poke(12'h010, 32'h0000_00AA);
    poke(12'h400, 32'h0000_0000);
    rst = 1'b0;
    tick();

    // Single fetch.
    do_access("fetch 100", 1'b0, IO_LW, 32'h100, 32'h0, 1'b0, 32'h3C01_8000);

    // First tie after reset goes to data; data re-requests in its ack cycle and the fetch wins next.
    sb.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF80));
    sb.push_back(mk(1'b0, 1'b0, 32'hA000_0000));
    sb.push_back(mk(1'b1, 1'b0, 32'h0000_0080));
    mem_req = 1'b1; mem_mode = IO_LB; mem_addr = 32'h203;
    if_req = 1'b1; if_addr = 32'h0;
    m1 = -1; f1 = -1; m2 = -1;
    for (int n = 1; n <= 60 && m2 < 0; n++) begin
      tick();
      if (mem_ack) begin
        if (m1 < 0) begin
          m1 = n;
          mem_mode = IO_LBU;
        end else begin
          m2 = n;
          mem_req = 1'b0;
        end
      end
      if (if_ack) begin
        f1 = n;
        if_req = 1'b0;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("tie mem first cycle", 32'(m1), 32'(W + 2));
    check("tie fetch cycle", 32'(f1), 32'(2 * W + 5));
    check("tie mem second cycle", 32'(m2), 32'(3 * W + 8));
    tick();

    // Store with wait states, then read it back.
    do_access("sw 400", 1'b1, IO_SW, 32'h400, 32'hDEAD_BEEF, 1'b0, 32'h0);
    check("sw ram word", peek(12'h400), 32'hDEAD_BEEF);
    do_access("lw 400", 1'b1, IO_LW, 32'h400, 32'h0, 1'b0, 32'hDEAD_BEEF);
    do_access("lh 402", 1'b1, IO_LH, 32'h402, 32'h0, 1'b0, 32'hFFFF_DEAD);

    // Misaligned and invalid modes never touch the RAM.
    do_access("sh 401 mis", 1'b1, IO_SH, 32'h401, 32'h1234, 1'b1, 32'h0);
    do_access("lw 402 mis", 1'b1, IO_LW, 32'h402, 32'h0, 1'b1, 32'h0);
    do_access("fetch 6 mis", 1'b0, IO_LW, 32'h6, 32'h0, 1'b1, 32'h0);
    do_access("nop mode", 1'b1, IO_NOP, 32'h400, 32'h0, 1'b1, 32'h0);
    do_access("bad mode", 1'b1, 4'hF, 32'h400, 32'h0, 1'b1, 32'h0);
    check("mis ram unchanged", peek(12'h400), 32'hDEAD_BEEF);

    // Halfword store on the upper half, confirmed with a word load.
    do_access("sh 402", 1'b1, IO_SH, 32'h402, 32'hCAFE_1234, 1'b0, 32'h0);
    do_access("lw 400 after sh", 1'b1, IO_LW, 32'h400, 32'h0, 1'b0, 32'h1234_BEEF);

    // Reset in the final access cycle of a byte store aborts with no write and no ack.
    w0 = ram_writes;
    mem_req = 1'b1; mem_mode = IO_SB; mem_addr = 32'h10; mem_wdata = 32'h55;
    for (int n = 1; n <= W + 1; n++) tick();
    check("abort busy before rst", 32'(busy), 32'd1);
    check("abort store strobe", 32'(ram_mode), 32'(IO_SB));
    rst = 1'b1;
    #1;
    check("abort ram_mode in rst", 32'(ram_mode), 32'(IO_NOP));
    mem_req = 1'b0;
    tick();
    check("abort busy", 32'(busy), 32'd0);
    check("abort mem_ack", 32'({mem_ack, mem_err}), 32'd0);
    check("abort ram_addr", ram_addr, 32'd0);
    check("abort ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    tick();
    check("abort ram word", peek(12'h010), 32'h0000_00AA);
    check("abort writes", 32'(ram_writes - w0), 32'd0);

    // Back-to-back fetches with the request held and the address advanced on each ack.
    sb.push_back(mk(1'b0, 1'b0, 32'hA000_0000));
    sb.push_back(mk(1'b0, 1'b0, 32'hA000_0004));
    sb.push_back(mk(1'b0, 1'b0, 32'hA000_0008));
    if_req = 1'b1; if_addr = 32'h0;
    k = 0;
    acks[0] = -1; acks[1] = -1; acks[2] = -1;
    for (int n = 1; n <= 60 && k < 3; n++) begin
      tick();
      if (if_ack) begin
        acks[k] = n;
        k++;
        if_addr = if_addr + 32'd4;
        if (k == 3) if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    check("b2b ack 0", 32'(acks[0]), 32'(W + 2));
    check("b2b ack 1", 32'(acks[1]), 32'(2 * W + 5));
    check("b2b ack 2", 32'(acks[2]), 32'(3 * W + 8));
    tick();
    tick();
    check("sb drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
